dmem_responder: RTL

- Data-memory responder for the single-cycle MIPS-54 core. It serves the core's DM_CS/DM_W/DM_R/Bit_S store/load interface.
- Holds a word array with big-endian byte lanes. Writes commit synchronously, with byte and halfword merge.
- Returns load data shifted so the addressed byte or halfword sits at DM_rdata[31:24] or [31:16], which is where the core's lb/lbu/lh/lhu extension expects it.
- Adds sticky access-error capture and a committed-write counter for debug and verification.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_lane_merge.sv | 51 +++++
 rtl/dmem_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared codes for the MIPS-54 data-memory responder.
//   BS_*            : store-size codes carried on Bit_S (3 is handled as word)
//   err_cause_e     : sticky access-error cause codes
//   DMEM_BASE_DEFAULT : byte address mapped to word 0
package dmem_pkg;

    localparam logic [1:0] BS_BYTE = 2'd0;
    localparam logic [1:0] BS_HALF = 2'd1;
    localparam logic [1:0] BS_WORD = 2'd2;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } err_cause_e;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-data-memory bus (DM_CS/DM_W/DM_R/Bit_S store/load interface).
//   master : core side, drives the request and reads DM_rdata
//   slave  : memory side, receives the request and drives DM_rdata
interface dmem_if;

    logic        DM_CS;
    logic        DM_W;
    logic        DM_R;
    logic [31:0] DM_addr;
    logic [31:0] DM_wdata;
    logic [1:0]  Bit_S;
    logic [31:0] DM_rdata;

    modport master (
        output DM_CS, DM_W, DM_R, DM_addr, DM_wdata, Bit_S,
        input  DM_rdata
    );

    modport slave (
        input  DM_CS, DM_W, DM_R, DM_addr, DM_wdata, Bit_S,
        output DM_rdata
    );

endinterface

// File: rtl/dmem_lane_merge.sv
// Combinational store merge into a big-endian word.
//   old_word : current contents of the addressed word
//   wdata    : store data; low byte / halfword used for sb / sh
//   bit_s    : store size code
//   lane     : byte offset within the word (lane 0 = bits 31:24)
//   merged   : word with the stored lanes replaced
//   aligned  : store size is legal at this lane
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  bit_s,
    input  logic [1:0]  lane,
    output logic [31:0] merged,
    output logic        aligned
);

    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] data;

    assign shamt = {lane, 3'b000};

    // Data is placed at the top of the word and shifted right so lane k
    // lands on bits [31-8k -: 8], matching the big-endian lane map.
    always_comb begin
        mask    = '0;
        data    = '0;
        aligned = 1'b0;
        case (bit_s)
            BS_BYTE: begin
                mask    = 32'hFF00_0000 >> shamt;
                data    = {wdata[7:0], 24'h00_0000} >> shamt;
                aligned = 1'b1;
            end
            BS_HALF: begin
                mask    = 32'hFFFF_0000 >> shamt;
                data    = {wdata[15:0], 16'h0000} >> shamt;
                aligned = ~lane[0];
            end
            default: begin
                mask    = 32'hFFFF_FFFF;
                data    = wdata;
                aligned = (lane == 2'd0);
            end
        endcase
        merged = (old_word & ~mask) | (data & mask);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle MIPS-54 core.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset; clears memory and status
//   bus       : dmem_if.slave request/response bus (combinational reads)
//   err_clr   : clears the sticky error
//   err       : sticky access-error flag
//   err_cause : cause of the first error since clear/reset
//   err_addr  : DM_addr of the first error since clear/reset
//   wr_cnt    : committed-write counter, wraps
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE  = DMEM_BASE_DEFAULT,
    parameter int          DEPTH = 1024,
    parameter int          CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    dmem_if.slave            bus,
    input  logic             err_clr,
    output logic             err,
    output logic [1:0]       err_cause,
    output logic [31:0]      err_addr,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    logic [31:0] mem [DEPTH];

    logic [31:0] off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] cur_word;
    logic [31:0] merged;
    logic        aligned;
    logic        access_wr;
    logic        commit;
    logic        err_now;
    err_cause_e  new_cause;
    err_cause_e  cause_q;

    assign off      = bus.DM_addr - BASE;
    assign in_range = ({1'b0, off} < SPAN);
    assign idx      = off[AW+1:2];
    assign lane     = off[1:0];
    assign cur_word = mem[idx];

    // Reads always see the pre-edge contents, so a same-cycle store to the
    // same word only becomes visible after the edge.
    assign bus.DM_rdata = (bus.DM_CS && bus.DM_R && in_range)
                        ? (cur_word << {lane, 3'b000}) : 32'h0;

    dmem_lane_merge u_merge (
        .old_word (cur_word),
        .wdata    (bus.DM_wdata),
        .bit_s    (bus.Bit_S),
        .lane     (lane),
        .merged   (merged),
        .aligned  (aligned)
    );

    assign access_wr = bus.DM_CS && bus.DM_W;
    assign commit    = access_wr && in_range && aligned;
    assign err_now   = access_wr && !(in_range && aligned);
    assign new_cause = in_range ? ERR_MISALIGN : ERR_RANGE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[idx] <= merged;
        end
    end

    // A new error overrides a simultaneous clear; otherwise the first
    // error since clear is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err      <= 1'b0;
            cause_q  <= ERR_NONE;
            err_addr <= '0;
        end else if (err_now && (!err || err_clr)) begin
            err      <= 1'b1;
            cause_q  <= new_cause;
            err_addr <= bus.DM_addr;
        end else if (err_clr) begin
            err      <= 1'b0;
            cause_q  <= ERR_NONE;
            err_addr <= '0;
        end
    end

    assign err_cause = cause_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
        end else if (commit) begin
            wr_cnt <= wr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
